// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter sharing one data memory between
// the core load/store port (m0) and a second bus master (m1).
module dram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              dram_read,
    output logic              dram_write,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_data_out,
    input  logic [DATA_W-1:0] dram_data_in,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              grant1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        grant1   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the master that did not go last wins
                    grant1  = (m0_req && m1_req) ? ~last_q : m1_req;
                    owner_d = grant1;
                    write_d = grant1 ? m1_write : m0_write;
                    addr_d  = grant1 ? m1_addr  : m0_addr;
                    wdata_d = grant1 ? m1_wdata : m0_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    if (owner_q) rdata1_d = dram_data_in;
                    else         rdata0_d = dram_data_in;
                end
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                state_d = RELEASE;
            end
            RELEASE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign dram_read     = (state_q == ACCESS) && !write_q;
    assign dram_write    = (state_q == ACCESS) &&  write_q;
    assign dram_addr     = addr_q;
    assign dram_data_out = wdata_q;
    assign m0_rdata      = rdata0_q;
    assign m1_rdata      = rdata1_q;
    assign m0_ack        = ack0_q;
    assign m1_ack        = ack1_q;
    assign busy          = (state_q != IDLE);

endmodule
